axi_lite_master: RTL and testbench

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

---
 rtl/axi_lite_master.sv | 169 ++++++++++++++++
 tb/tb_axi_lite_master.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master that turns local cmd/rsp handshakes into AXI transactions.
// Define AXIL_MASTER_TIMEOUT_EN to add a watchdog that aborts a stalled transaction after TIMEOUT_CYCLES.
module axi_lite_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;

  // A write channel counts as finished once its beat is taken now or was taken earlier.
  assign aw_done = !AWVALID || AWREADY;
  assign w_done  = !WVALID  || WREADY;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wdog;
  logic          wdog_hit;
  logic          timeout_q;

  assign wdog_hit    = (state != IDLE) && (state != RSP) && (wdog == CW'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = timeout_q;
`else
  assign rsp_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
      AWADDR    <= '0;
      AWVALID   <= 1'b0;
      WDATA     <= '0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARADDR    <= '0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
      wdog      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef AXIL_MASTER_TIMEOUT_EN
      if (state != IDLE && state != RSP)
        wdog <= wdog + CW'(1);
`endif
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
            wdog      <= '0;
`endif
            if (cmd_write) begin
              state   <= WR_REQ;
              AWADDR  <= cmd_addr;
              WDATA   <= cmd_wdata;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
            end else begin
              state   <= RD_REQ;
              ARADDR  <= cmd_addr;
              ARVALID <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (AWVALID && AWREADY)
            AWVALID <= 1'b0;
          if (WVALID && WREADY)
            WVALID <= 1'b0;
          if (aw_done && w_done) begin
            state  <= WR_RESP;
            BREADY <= 1'b1;
          end
        end
        WR_RESP: begin
          if (BVALID) begin
            rsp_resp  <= BRESP;
            BREADY    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RD_REQ: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (RVALID) begin
            rsp_rdata <= RDATA;
            rsp_resp  <= RRESP;
            RREADY    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
`ifdef AXIL_MASTER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
`ifdef AXIL_MASTER_TIMEOUT_EN
      // Watchdog abort overrides any handshake landing on the same edge.
      if (wdog_hit) begin
        AWVALID   <= 1'b0;
        WVALID    <= 1'b0;
        BREADY    <= 1'b0;
        ARVALID   <= 1'b0;
        RREADY    <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_resp  <= 2'b10;
        timeout_q <= 1'b1;
        state     <= RSP;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Scoreboard bench for axi_lite_master: tasks play the local user and an AXI-Lite slave with
// programmable ready/valid delays; expected responses come from a small memory model.
module tb_axi_lite_master;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  always #5 ACLK = ~ACLK;

  axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        timeout;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] last_rdata = 32'h0;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic push_exp(input logic [31:0] rd, input logic [1:0] resp, input logic to);
    exp_t e;
    e.rdata = rd; e.resp = resp; e.timeout = to;
    sbq.push_back(e);
  endtask

  task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
    end
    @(negedge ACLK);
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cmd_busy: cmd_ready=%b required 0", cmd_ready);
    end
  endtask

  task automatic slave_write(input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] bresp,
                             input logic [31:0] exp_addr, input logic [31:0] exp_data, input bit spurious);
    int k;
    bit aw_done, w_done;
    k = 0; aw_done = 1'b0; w_done = 1'b0;
    while (!(aw_done && w_done) && k < 40) begin
      checks++;
      if (AWVALID !== !aw_done || (!aw_done && AWADDR !== exp_addr)) begin
        errors++;
        $display("[TB] FAIL aw_channel: AWVALID=%b AWADDR=%h required %b/%h", AWVALID, AWADDR, !aw_done, exp_addr);
      end
      checks++;
      if (WVALID !== !w_done || (!w_done && WDATA !== exp_data)) begin
        errors++;
        $display("[TB] FAIL w_channel: WVALID=%b WDATA=%h required %b/%h", WVALID, WDATA, !w_done, exp_data);
      end
      checks++;
      if (BREADY !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wr_req_ctl: BREADY=%b rsp_valid=%b cmd_ready=%b required 0/0/0", BREADY, rsp_valid, cmd_ready);
      end
      AWREADY = !aw_done && (k >= aw_dly);
      WREADY  = !w_done && (k >= w_dly);
      BVALID  = spurious;
      BRESP   = spurious ? 2'b11 : 2'b00;
      if (AWREADY && AWVALID) aw_done = 1'b1;
      if (WREADY && WVALID) w_done = 1'b1;
      @(negedge ACLK);
      k++;
    end
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    checks++;
    if (!(aw_done && w_done)) begin
      errors++;
      $display("[TB] FAIL wr_handshake: aw_done=%b w_done=%b required 1/1", aw_done, w_done);
    end
    for (int i = 0; i < b_dly; i++) begin
      checks++;
      if (BREADY !== 1'b1 || AWVALID !== 1'b0 || WVALID !== 1'b0 || rsp_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wr_resp_wait: BREADY=%b AWVALID=%b WVALID=%b rsp_valid=%b required 1/0/0/0", BREADY, AWVALID, WVALID, rsp_valid);
      end
      @(negedge ACLK);
    end
    checks++;
    if (BREADY !== 1'b1 || AWVALID !== 1'b0 || WVALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bready: BREADY=%b AWVALID=%b WVALID=%b required 1/0/0", BREADY, AWVALID, WVALID);
    end
    BVALID = 1'b1; BRESP = bresp;
    @(negedge ACLK);
    BVALID = 1'b0; BRESP = 2'b00;
    checks++;
    if (BREADY !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b_accept: BREADY=%b rsp_valid=%b required 0/1", BREADY, rsp_valid);
    end
  endtask

  task automatic slave_read(input int ar_dly, input int r_dly, input logic [1:0] rresp,
                            input logic [31:0] exp_addr, input bit spurious);
    int k;
    bit done;
    logic [31:0] seen_addr;
    k = 0; done = 1'b0; seen_addr = 32'h0;
    while (!done && k < 40) begin
      checks++;
      if (ARVALID !== 1'b1 || ARADDR !== exp_addr || RREADY !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ar_channel: ARVALID=%b ARADDR=%h RREADY=%b cmd_ready=%b rsp_valid=%b required 1/%h/0/0/0",
                 ARVALID, ARADDR, RREADY, cmd_ready, rsp_valid, exp_addr);
      end
      ARREADY = (k >= ar_dly);
      RVALID  = spurious;
      RDATA   = spurious ? 32'hBAD0_BAD0 : 32'h0;
      RRESP   = spurious ? 2'b11 : 2'b00;
      seen_addr = ARADDR;
      done = ARREADY && ARVALID;
      @(negedge ACLK);
      k++;
    end
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00;
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL ar_handshake: done=%b required 1", done);
    end
    for (int i = 0; i < r_dly; i++) begin
      checks++;
      if (RREADY !== 1'b1 || ARVALID !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rd_data_wait: RREADY=%b ARVALID=%b rsp_valid=%b cmd_ready=%b required 1/0/0/0", RREADY, ARVALID, rsp_valid, cmd_ready);
      end
      @(negedge ACLK);
    end
    checks++;
    if (RREADY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rready: RREADY=%b required 1", RREADY);
    end
    RVALID = 1'b1; RDATA = model_rd(seen_addr); RRESP = rresp;
    @(negedge ACLK);
    RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00;
    checks++;
    if (RREADY !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL r_accept: RREADY=%b rsp_valid=%b required 0/1", RREADY, rsp_valid);
    end
  endtask

  task automatic collect_rsp(input int stall);
    int n;
    exp_t e;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || sbq.size() == 0) begin
      errors++;
      $display("[TB] FAIL rsp_arrival: rsp_valid=%b pending=%0d required 1/>0", rsp_valid, sbq.size());
    end
    if (sbq.size() == 0) begin
      e.rdata = 32'h0; e.resp = 2'b00; e.timeout = 1'b0;
    end else begin
      e = sbq.pop_front();
    end
    for (int i = 0; i < stall; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_resp !== e.resp || cmd_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rsp_hold: valid=%b rdata=%h resp=%b cmd_ready=%b required 1/%h/%b/0", rsp_valid, rsp_rdata, rsp_resp, cmd_ready, e.rdata, e.resp);
      end
      @(negedge ACLK);
    end
    checks++;
    if (rsp_rdata !== e.rdata) begin
      errors++;
      $display("[TB] FAIL rsp_rdata: got %h required %h", rsp_rdata, e.rdata);
    end
    checks++;
    if (rsp_resp !== e.resp) begin
      errors++;
      $display("[TB] FAIL rsp_resp: got %b required %b", rsp_resp, e.resp);
    end
    checks++;
    if (rsp_timeout !== e.timeout) begin
      errors++;
      $display("[TB] FAIL rsp_timeout: got %b required %b", rsp_timeout, e.timeout);
    end
    rsp_ready = 1'b1;
    @(negedge ACLK);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rsp_release: rsp_valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; rsp_ready = 1'b0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00;
    repeat (3) @(negedge ACLK);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_timeout, AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_ctl: got %b required 00000000",
               {cmd_ready, rsp_valid, rsp_timeout, AWVALID, WVALID, BREADY, ARVALID, RREADY});
    end
    checks++;
    if (rsp_rdata !== 32'h0 || rsp_resp !== 2'b00 || AWADDR !== 32'h0 || WDATA !== 32'h0 || ARADDR !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: rdata=%h resp=%b awaddr=%h wdata=%h araddr=%h required all 0", rsp_rdata, rsp_resp, AWADDR, WDATA, ARADDR);
    end
    ARESETn = 1'b1;
    @(negedge ACLK);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_write_same_cycle();
    push_exp(last_rdata, 2'b00, 1'b0);
    mem[32'h10] = 32'hDEAD_BEEF;
    issue_cmd(1'b1, 32'h10, 32'hDEAD_BEEF);
    slave_write(0, 0, 0, 2'b00, 32'h10, 32'hDEAD_BEEF, 1'b0);
    collect_rsp(0);
  endtask

  task automatic test_write_w_late();
    push_exp(last_rdata, 2'b10, 1'b0);
    mem[32'h20] = 32'h1234_5678;
    issue_cmd(1'b1, 32'h20, 32'h1234_5678);
    slave_write(0, 3, 1, 2'b10, 32'h20, 32'h1234_5678, 1'b1);
    collect_rsp(1);
  endtask

  task automatic test_read_stall();
    last_rdata = model_rd(32'h10);
    push_exp(last_rdata, 2'b00, 1'b0);
    issue_cmd(1'b0, 32'h10, 32'h0);
    slave_read(1, 5, 2'b00, 32'h10, 1'b1);
    collect_rsp(4);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d;
    bit wr;
    last_rdata = model_rd(32'h20);
    push_exp(last_rdata, 2'b01, 1'b0);
    issue_cmd(1'b0, 32'h20, 32'h0);
    // A second command waits on the port while the read is in flight.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'hCAFE_F00D;
    slave_read(0, 1, 2'b01, 32'h20, 1'b0);
    checks++;
    if (AWVALID !== 1'b0 || WVALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pending_cmd: AWVALID=%b WVALID=%b required 0/0", AWVALID, WVALID);
    end
    collect_rsp(2);
    push_exp(last_rdata, 2'b00, 1'b0);
    mem[32'h30] = 32'hCAFE_F00D;
    issue_cmd(1'b1, 32'h30, 32'hCAFE_F00D);
    slave_write(0, 0, 0, 2'b00, 32'h30, 32'hCAFE_F00D, 1'b0);
    collect_rsp(0);
    for (int i = 0; i < 6; i++) begin
      a  = 32'h100 + 32'((i % 3) * 4);
      wr = (i < 3);
      if (wr) begin
        d = $urandom;
        push_exp(last_rdata, 2'b00, 1'b0);
        mem[a] = d;
        issue_cmd(1'b1, a, d);
        slave_write(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), 2'b00, a, d, 1'b0);
      end else begin
        last_rdata = model_rd(a);
        push_exp(last_rdata, 2'b00, 1'b0);
        issue_cmd(1'b0, a, 32'h0);
        slave_read(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 2'b00, a, 1'b0);
      end
      collect_rsp(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_reset_mid_read();
    issue_cmd(1'b0, 32'h20, 32'h0);
    ARREADY = 1'b1;
    @(negedge ACLK);
    ARREADY = 1'b0;
    checks++;
    if (RREADY !== 1'b1 || ARVALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rd_data_entry: RREADY=%b ARVALID=%b required 1/0", RREADY, ARVALID);
    end
    @(negedge ACLK);
    ARESETn = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_timeout, AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midreset_ctl: got %b required 00000000",
               {cmd_ready, rsp_valid, rsp_timeout, AWVALID, WVALID, BREADY, ARVALID, RREADY});
    end
    checks++;
    if (rsp_rdata !== 32'h0 || rsp_resp !== 2'b00 || AWADDR !== 32'h0 || WDATA !== 32'h0 || ARADDR !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_data: rdata=%h resp=%b awaddr=%h wdata=%h araddr=%h required all 0", rsp_rdata, rsp_resp, AWADDR, WDATA, ARADDR);
    end
    last_rdata = 32'h0;
    RVALID = 1'b1; RDATA = 32'h5555_AAAA;
    @(negedge ACLK);
    @(negedge ACLK);
    RVALID = 1'b0; RDATA = 32'h0;
    ARESETn = 1'b1;
    @(negedge ACLK);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || RREADY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_release: cmd_ready=%b rsp_valid=%b RREADY=%b required 1/0/0", cmd_ready, rsp_valid, RREADY);
    end
    push_exp(last_rdata, 2'b00, 1'b0);
    mem[32'h34] = 32'hA5A5_0F0F;
    issue_cmd(1'b1, 32'h34, 32'hA5A5_0F0F);
    slave_write(1, 0, 0, 2'b00, 32'h34, 32'hA5A5_0F0F, 1'b0);
    collect_rsp(0);
    last_rdata = model_rd(32'h34);
    push_exp(last_rdata, 2'b00, 1'b0);
    issue_cmd(1'b0, 32'h34, 32'h0);
    slave_read(0, 0, 2'b00, 32'h34, 1'b0);
    collect_rsp(0);
  endtask

  task automatic test_timeout();
    int n;
    issue_cmd(1'b0, 32'h60, 32'h0);
`ifdef AXIL_MASTER_TIMEOUT_EN
    n = 0;
    while (ARVALID === 1'b1 && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("[TB] FAIL wdog_len: ARVALID cycles=%0d required 8", n);
    end
    checks++;
    if (ARVALID !== 1'b0 || RREADY !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wdog_abort: ARVALID=%b RREADY=%b rsp_valid=%b required 0/0/1", ARVALID, RREADY, rsp_valid);
    end
    push_exp(last_rdata, 2'b10, 1'b1);
    collect_rsp(1);
`else
    n = 0;
    repeat (20) begin
      if (ARVALID !== 1'b1 || rsp_timeout !== 1'b0 || rsp_valid !== 1'b0) n++;
      @(negedge ACLK);
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("[TB] FAIL no_wdog_wait: bad cycles=%0d required 0", n);
    end
    last_rdata = model_rd(32'h60);
    push_exp(last_rdata, 2'b00, 1'b0);
    slave_read(0, 0, 2'b00, 32'h60, 1'b0);
    collect_rsp(0);
`endif
    last_rdata = model_rd(32'h10);
    push_exp(last_rdata, 2'b00, 1'b0);
    issue_cmd(1'b0, 32'h10, 32'h0);
    slave_read(0, 0, 2'b00, 32'h10, 1'b0);
    collect_rsp(0);
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_write_w_late();
    test_read_stall();
    test_back_to_back();
    test_reset_mid_read();
    test_timeout();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: pending=%0d required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "[TB] stopped");
  end

endmodule
